hex_entry_ctrl: RTL and testbench

HEX_ENTRY_CTRL -- requirements
Module: hex_entry_ctrl

---
 rtl/hex_entry_pkg.sv | 15 +
 rtl/scan_hex_decode.sv | 33 +++
 rtl/hex_entry_ctrl.sv | 118 +++++++++++
 tb/tb_hex_entry_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_entry_pkg.sv
// Shared constants for the hex entry controller: FSM state encoding and
// the PS/2 scan-code values the controller reacts to.
package hex_entry_pkg;

  localparam logic [1:0] S_MAKE  = 2'd0;
  localparam logic [1:0] S_BREAK = 2'd1;
  localparam logic [1:0] S_EXT   = 2'd2;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BKSP  = 8'h66;

endpackage

// File: rtl/scan_hex_decode.sv
// Combinational PS/2 set-2 make code to hex nibble decoder.
module scan_hex_decode (
  input  logic [7:0] code,
  output logic [3:0] nibble,
  output logic       is_hex
);

  // Map the sixteen hex key make codes; everything else is not a digit.
  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b1;
    case (code)
      8'h45: nibble = 4'h0;
      8'h16: nibble = 4'h1;
      8'h1E: nibble = 4'h2;
      8'h26: nibble = 4'h3;
      8'h25: nibble = 4'h4;
      8'h2E: nibble = 4'h5;
      8'h36: nibble = 4'h6;
      8'h3D: nibble = 4'h7;
      8'h3E: nibble = 4'h8;
      8'h46: nibble = 4'h9;
      8'h1C: nibble = 4'hA;
      8'h32: nibble = 4'hB;
      8'h21: nibble = 4'hC;
      8'h23: nibble = 4'hD;
      8'h24: nibble = 4'hE;
      8'h2B: nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_entry_ctrl.sv
// Hex number entry from a PS/2 keyboard byte stream.
// Digits shift in from the right; Enter commits, Esc clears, break and
// extended sequences are filtered out.
// Optional feature macro: HEX_ENTRY_BKSP_EN enables Backspace editing.
//
// state   | meaning
// S_MAKE  | waiting for a make code or a prefix byte
// S_BREAK | F0 seen, next byte is a key release and is dropped
// S_EXT   | E0 seen, next byte belongs to an extended key
module hex_entry_ctrl
  import hex_entry_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [7:0]            code_in,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [4*DIGITS-1:0]   entry_out,
  output logic [3:0]            digit_cnt,
  output logic                  value_valid,
  output logic                  overflow
);

  localparam int W = 4 * DIGITS;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] value_q, value_d;
  logic [W-1:0] entry_q, entry_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         value_valid_q, value_valid_d;
  logic         overflow_q, overflow_d;

  logic [3:0]   nibble;
  logic         is_hex;

  scan_hex_decode u_decode (
    .code   (code_in),
    .nibble (nibble),
    .is_hex (is_hex)
  );

  // Next-state logic; pulses default low so they last a single cycle.
  always_comb begin
    state_d       = state_q;
    value_d       = value_q;
    entry_d       = entry_q;
    cnt_d         = cnt_q;
    value_valid_d = 1'b0;
    overflow_d    = 1'b0;
    if (code_valid) begin
      case (state_q)
        S_MAKE: begin
          if (code_in == SC_BREAK) begin
            state_d = S_BREAK;
          end else if (code_in == SC_EXT) begin
            state_d = S_EXT;
          end else if (is_hex) begin
            if (cnt_q < 4'(DIGITS)) begin
              entry_d = (entry_q << 4) | W'(nibble);
              cnt_d   = cnt_q + 4'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (code_in == SC_ENTER) begin
            value_d       = entry_q;
            entry_d       = '0;
            cnt_d         = 4'd0;
            value_valid_d = 1'b1;
          end else if (code_in == SC_ESC) begin
            entry_d = '0;
            cnt_d   = 4'd0;
          end
`ifdef HEX_ENTRY_BKSP_EN
          else if (code_in == SC_BKSP && cnt_q != 4'd0) begin
            entry_d = entry_q >> 4;
            cnt_d   = cnt_q - 4'd1;
          end
`endif
        end
        S_BREAK: state_d = S_MAKE;
        S_EXT: begin
          // An extended key release is E0 F0 xx; route it through S_BREAK.
          if (code_in == SC_BREAK) state_d = S_BREAK;
          else                     state_d = S_MAKE;
        end
        default: state_d = S_MAKE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_MAKE;
      value_q       <= '0;
      entry_q       <= '0;
      cnt_q         <= 4'd0;
      value_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      entry_q       <= entry_d;
      cnt_q         <= cnt_d;
      value_valid_q <= value_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign value_out   = value_q;
  assign entry_out   = entry_q;
  assign digit_cnt   = cnt_q;
  assign value_valid = value_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Directed bench for hex_entry_ctrl (DIGITS=4).
module tb_hex_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        code_valid = 1'b0;
  logic [7:0]  code_in = 8'h00;
  logic [15:0] value_out;
  logic [15:0] entry_out;
  logic [3:0]  digit_cnt;
  logic        value_valid;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  code;
    logic [15:0] val;
    logic [15:0] ent;
    logic [3:0]  cnt;
    logic        vv;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  hex_entry_ctrl #(.DIGITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code_in     (code_in),
    .value_out   (value_out),
    .entry_out   (entry_out),
    .digit_cnt   (digit_cnt),
    .value_valid (value_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic [15:0] v, input logic [15:0] e,
                     input logic [3:0] n, input logic vv, input logic ov);
    vec_t t;
    t.code = c; t.val = v; t.ent = e; t.cnt = n; t.vv = vv; t.ov = ov;
    vecs.push_back(t);
  endtask

  // Strobe one byte for one cycle; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_valid = 1'b1;
    code_in    = b;
    @(negedge clk);
    code_valid = 1'b0;
    code_in    = 8'h00;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] v, input logic [15:0] e,
                         input logic [3:0] n, input logic vv, input logic ov);
    chk({tag, ".value"}, 32'(value_out), 32'(v));
    chk({tag, ".entry"}, 32'(entry_out), 32'(e));
    chk({tag, ".cnt"},   32'(digit_cnt), 32'(n));
    chk({tag, ".vv"},    32'(value_valid), 32'(vv));
    chk({tag, ".ov"},    32'(overflow), 32'(ov));
  endtask

  initial begin
    // entry and commit
    add(8'h16, 16'h0000, 16'h0001, 4'd1, 1'b0, 1'b0);
    add(8'h1E, 16'h0000, 16'h0012, 4'd2, 1'b0, 1'b0);
    add(8'h26, 16'h0000, 16'h0123, 4'd3, 1'b0, 1'b0);
    add(8'h25, 16'h0000, 16'h1234, 4'd4, 1'b0, 1'b0);
    add(8'h5A, 16'h1234, 16'h0000, 4'd0, 1'b1, 1'b0);
    // break filtering
    add(8'h1C, 16'h1234, 16'h000A, 4'd1, 1'b0, 1'b0);
    add(8'hF0, 16'h1234, 16'h000A, 4'd1, 1'b0, 1'b0);
    add(8'h1C, 16'h1234, 16'h000A, 4'd1, 1'b0, 1'b0);
    add(8'h5A, 16'h000A, 16'h0000, 4'd0, 1'b1, 1'b0);
    // full buffer
    add(8'h16, 16'h000A, 16'h0001, 4'd1, 1'b0, 1'b0);
    add(8'h1E, 16'h000A, 16'h0012, 4'd2, 1'b0, 1'b0);
    add(8'h26, 16'h000A, 16'h0123, 4'd3, 1'b0, 1'b0);
    add(8'h25, 16'h000A, 16'h1234, 4'd4, 1'b0, 1'b0);
    add(8'h2E, 16'h000A, 16'h1234, 4'd4, 1'b0, 1'b1);
    add(8'h5A, 16'h1234, 16'h0000, 4'd0, 1'b1, 1'b0);
    // extended keys and clear
    add(8'hE0, 16'h1234, 16'h0000, 4'd0, 1'b0, 1'b0);
    add(8'h5A, 16'h1234, 16'h0000, 4'd0, 1'b0, 1'b0);
    add(8'h16, 16'h1234, 16'h0001, 4'd1, 1'b0, 1'b0);
    add(8'h76, 16'h1234, 16'h0000, 4'd0, 1'b0, 1'b0);
    // empty commit
    add(8'h5A, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);
    // remaining digit decodes
    add(8'h45, 16'h0000, 16'h0000, 4'd1, 1'b0, 1'b0);
    add(8'h2B, 16'h0000, 16'h000F, 4'd2, 1'b0, 1'b0);
    add(8'h32, 16'h0000, 16'h00FB, 4'd3, 1'b0, 1'b0);
    add(8'h21, 16'h0000, 16'h0FBC, 4'd4, 1'b0, 1'b0);
    add(8'h5A, 16'h0FBC, 16'h0000, 4'd0, 1'b1, 1'b0);
    add(8'h23, 16'h0FBC, 16'h000D, 4'd1, 1'b0, 1'b0);
    add(8'h24, 16'h0FBC, 16'h00DE, 4'd2, 1'b0, 1'b0);
    add(8'h3D, 16'h0FBC, 16'h0DE7, 4'd3, 1'b0, 1'b0);
    add(8'h3E, 16'h0FBC, 16'hDE78, 4'd4, 1'b0, 1'b0);
    add(8'h5A, 16'hDE78, 16'h0000, 4'd0, 1'b1, 1'b0);
    add(8'h46, 16'hDE78, 16'h0009, 4'd1, 1'b0, 1'b0);
    add(8'h36, 16'hDE78, 16'h0096, 4'd2, 1'b0, 1'b0);
    add(8'h1D, 16'hDE78, 16'h0096, 4'd2, 1'b0, 1'b0);
    add(8'h2E, 16'hDE78, 16'h0965, 4'd3, 1'b0, 1'b0);
    add(8'h5A, 16'h0965, 16'h0000, 4'd0, 1'b1, 1'b0);
    // extended release E0 F0 xx is fully discarded
    add(8'hE0, 16'h0965, 16'h0000, 4'd0, 1'b0, 1'b0);
    add(8'hF0, 16'h0965, 16'h0000, 4'd0, 1'b0, 1'b0);
    add(8'h16, 16'h0965, 16'h0000, 4'd0, 1'b0, 1'b0);
    add(8'h5A, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0);

    // reset state
    #1;
    chk_all("reset_async", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_all("reset", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      send(vecs[i].code);
      chk_all($sformatf("vec%0d", i), vecs[i].val, vecs[i].ent, vecs[i].cnt,
              vecs[i].vv, vecs[i].ov);
    end

    // idle cycles change nothing and pulses drop after one cycle
    send(8'h16);
    send(8'h5A);
    chk("vv_pulse", 32'(value_valid), 32'd1);
    @(negedge clk);
    chk_all("idle_after_commit", 16'h0001, 16'h0, 4'd0, 1'b0, 1'b0);

    // back-to-back strobes: pulse lasts exactly one cycle
    @(negedge clk);
    code_valid = 1'b1; code_in = 8'h5A;
    @(negedge clk);
    code_in = 8'h26;
    chk("b2b.vv_first", 32'(value_valid), 32'd1);
    @(negedge clk);
    code_valid = 1'b0;
    chk("b2b.vv_second", 32'(value_valid), 32'd0);
    chk("b2b.entry", 32'(entry_out), 32'h3);
    send(8'h76);

    // backspace (and backspace on empty buffer)
    send(8'h66);
    chk("bksp_empty.cnt", 32'(digit_cnt), 32'd0);
    send(8'h16);
    send(8'h1E);
    send(8'h66);
`ifdef HEX_ENTRY_BKSP_EN
    chk("bksp.entry", 32'(entry_out), 32'h1);
    chk("bksp.cnt", 32'(digit_cnt), 32'd1);
`else
    chk("bksp.entry", 32'(entry_out), 32'h12);
    chk("bksp.cnt", 32'(digit_cnt), 32'd2);
`endif
    send(8'h26);
    send(8'h5A);
`ifdef HEX_ENTRY_BKSP_EN
    chk("bksp.value", 32'(value_out), 32'h0013);
`else
    chk("bksp.value", 32'(value_out), 32'h0123);
`endif
    chk("bksp.vv", 32'(value_valid), 32'd1);

    // reset mid-sequence drops the pending break prefix
    send(8'h16);
    send(8'hF0);
    reset = 1'b1;
    #1;
    chk_all("midreset_async", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(8'h1E);
    chk("midreset.entry", 32'(entry_out), 32'h2);
    send(8'h5A);
    chk("midreset.value", 32'(value_out), 32'h0002);
    chk("midreset.vv", 32'(value_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // value_valid and overflow must never be high together
  always @(negedge clk) begin
    if (!reset && value_valid && overflow) begin
      checks++;
      errors++;
      $display("FAIL exclusive_pulses: vv=%0b ov=%0b required not both", value_valid, overflow);
    end
  end

endmodule
